axi_w_burst_buffer: RTL and testbench
=====================================

// Module: axi_w_burst_buffer
// PURPOSE
//  Single-clock AXI4 write-data (W) channel buffer between the AXI slave port and the memory controller write path.
//  Full valid/ready handshake on both sides; all DEPTH entries usable (occupancy counter, no wasted slot).
//  Adds programmable almost-full/almost-empty flags, a completed-burst counter, a synchronous flush,
//  and an optional store-and-forward mode that presents beats downstream only once a complete burst is held.
// PARAMETERS
//  FIFO_DEPTH          128             entries, any value >= 2 (power of 2 not required)
//  DATA_WIDTH          32              WDATA width, multiple of 8
//  STRB_WIDTH          DATA_WIDTH/8    WSTRB width
//  ALMOST_FULL_THRESH  FIFO_DEPTH-2    almost_full when count >= this value
//  ALMOST_EMPTY_THRESH 2               almost_empty when count <= this value
//  STORE_FWD           0               0 = cut-through, 1 = store-and-forward (burst-gated output)
//  CNT_WIDTH           $clog2(FIFO_DEPTH+1)  width of the occupancy and burst counters (derived)
// PORTS
//  W_fifo_clk          in   1           single clock, rising edge
//  W_fifo_rst          in   1           asynchronous, active-high reset
//  W_fifo_flush        in   1           synchronous flush: discard all stored beats
//  in_fifo_WDATA       in   DATA_WIDTH  upstream write data
//  in_fifo_WSTRB       in   STRB_WIDTH  upstream byte strobes
//  in_fifo_WLAST       in   1           upstream last beat of burst
//  in_fifo_WVALID      in   1           upstream beat valid
//  in_fifo_WREADY      out  1           buffer can accept a beat
//  out_fifo_WDATA      out  DATA_WIDTH  head-of-queue data
//  out_fifo_WSTRB      out  STRB_WIDTH  head-of-queue strobes
//  out_fifo_WLAST      out  1           head-of-queue last flag
//  out_fifo_WVALID     out  1           head beat presented downstream
//  out_fifo_WREADY     in   1           downstream accepts the head beat
//  W_fifo_full         out  1           count == FIFO_DEPTH
//  W_fifo_empty        out  1           count == 0
//  W_fifo_almost_full  out  1           count >= ALMOST_FULL_THRESH
//  W_fifo_almost_empty out  1           count <= ALMOST_EMPTY_THRESH
//  W_fifo_count        out  CNT_WIDTH   stored beats, 0..FIFO_DEPTH
//  W_fifo_burst_count  out  CNT_WIDTH   stored complete bursts (stored beats with WLAST=1)
// BEHAVIOUR
//  Reset (async, W_fifo_rst=1): pointers, count and burst_count = 0.
//   Outputs: empty=1, full=0, almost_empty=1, almost_full=0, in_fifo_WREADY=0 while reset is held.
//   out_fifo_WVALID=0; out data/strb/last are don't-care but must not be X-propagated into control.
//  Push = in_fifo_WVALID & in_fifo_WREADY.
//   in_fifo_WREADY = !full & !flush & !rst; it never depends on a same-cycle pop.
//  Pop = out_fifo_WVALID & out_fifo_WREADY.
//  Head is first-word-fall-through: out_fifo_W* come combinationally from mem[r_ptr].
//   A beat pushed at edge N is visible at the output after edge N (1-cycle latency, cut-through).
//  out_fifo_WVALID:
//   STORE_FWD=0: !empty.
//   STORE_FWD=1: !empty & (burst_count != 0 | full). The full override releases bursts longer than
//   FIFO_DEPTH and prevents deadlock.
//  Payload is held stable while WVALID=1 and WREADY=0.
//  Pointers wrap from FIFO_DEPTH-1 to 0.
//  count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
//  burst_count: +1 on push with WLAST, -1 on pop with WLAST, unchanged if both occur.
//   Saturation is impossible by construction; assert on it.
//  Flush at edge N: pointers, count and burst_count = 0 after N. A same-cycle push is ignored
//   (WREADY=0); a same-cycle pop still completes at the downstream side, but its entry is discarded.
//  Reset asserted mid-burst clears everything immediately. No partial burst survives reset.
//  Flags are combinational from count, so they are valid in the same cycle as count.
// STRUCTURE
//  Package axi_w_buf_pkg:
//   - typedef struct packed {logic wlast; logic [STRB_WIDTH-1:0] wstrb; logic [DATA_WIDTH-1:0] wdata;}
//     w_beat_t (parametrised via localparams DATA_WIDTH_DEF=32, STRB_WIDTH_DEF=4);
//   - function ptr_inc(ptr, depth) giving the wrapping increment.
//  Sub-module w_buf_mem:
//   - 1 write / 1 read, sync write, async read, FIFO_DEPTH x $bits(w_beat_t);
//   - no reset on storage.
//  Top level: pointers, counters, flags, store-forward gating.
// TESTING
//  T1 reset/idle:
//   assert rst mid-cycle -> empty=1, WVALID=0, count=0 immediately (async); WREADY=1 first cycle after release.
//  T2 fill/drain, DEPTH=8:
//   push 8 beats (WDATA=0..7), WREADY held 0 downstream -> full=1, WREADY=0, count=8, almost_full from count 6.
//   Then drain -> output 0..7 in order, empty=1.
//  T3 simultaneous push+pop at count=8 (full):
//   no push accepted and count drops to 7.
//   Repeat at count=3 -> count stays 3, data order preserved across pointer wrap.
//  T4 STORE_FWD=1:
//   push 3 beats WLAST=0 -> WVALID stays 0. Push a 4th with WLAST=1 -> WVALID=1 the next cycle, burst_count=1.
//   Drain 4 -> burst_count=0.
//  T5 overlong burst, STORE_FWD=1, DEPTH=8:
//   push 8 beats with no WLAST -> full overrides the gate, WVALID=1, traffic continues, no deadlock.
//  T6 flush with count=5, burst_count=2 plus push and pop in the same cycle:
//   next cycle count=0, burst_count=0, empty=1; the pushed beat never appears at the output.

Source files
------------

// File: rtl/axi_w_buf_pkg.sv
// rtl/axi_w_buf_pkg.sv - shared types and helpers for the AXI W-channel burst buffer
// Purpose: beat record layout and the wrapping pointer increment used by the buffer.
// Contents: DATA_WIDTH_DEF/STRB_WIDTH_DEF, w_beat_t {wlast, wstrb, wdata}, ptr_inc().
package axi_w_buf_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int STRB_WIDTH_DEF = 4;

  // Field order matches the packed word stored in w_buf_mem: {wlast, wstrb, wdata}.
  typedef struct packed {
    logic                      wlast;
    logic [STRB_WIDTH_DEF-1:0] wstrb;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } w_beat_t;

  // Increment with wrap from depth-1 back to 0; depth need not be a power of two.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/axi_w_burst_buffer_mem.sv
// rtl/axi_w_burst_buffer_mem.sv - beat storage for the W-channel burst buffer
// Purpose: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port, no reset.
// Ports: clk, we, waddr, wdata (write side); raddr, rdata (combinational read side).
module w_buf_mem #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 37,
  parameter int PTR_W = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is combinational so the head beat falls through to the output.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_w_burst_buffer.sv
// rtl/axi_w_burst_buffer.sv - AXI4 W-channel buffer with burst tracking and store-and-forward
// Purpose: first-word-fall-through beat FIFO between the AXI slave W port and the memory write path.
// Ports: W_fifo_clk/W_fifo_rst/W_fifo_flush; in_fifo_W* upstream handshake; out_fifo_W* downstream
//        handshake; W_fifo_full/empty/almost_full/almost_empty flags; W_fifo_count beats held;
//        W_fifo_burst_count complete bursts held.
module axi_w_burst_buffer
  import axi_w_buf_pkg::*;
#(
  parameter int FIFO_DEPTH          = 128,
  parameter int DATA_WIDTH          = 32,
  parameter int STRB_WIDTH          = DATA_WIDTH / 8,
  parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2,
  parameter int STORE_FWD           = 0,
  parameter int CNT_WIDTH           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  W_fifo_clk,
  input  logic                  W_fifo_rst,
  input  logic                  W_fifo_flush,
  input  logic [DATA_WIDTH-1:0] in_fifo_WDATA,
  input  logic [STRB_WIDTH-1:0] in_fifo_WSTRB,
  input  logic                  in_fifo_WLAST,
  input  logic                  in_fifo_WVALID,
  output logic                  in_fifo_WREADY,
  output logic [DATA_WIDTH-1:0] out_fifo_WDATA,
  output logic [STRB_WIDTH-1:0] out_fifo_WSTRB,
  output logic                  out_fifo_WLAST,
  output logic                  out_fifo_WVALID,
  input  logic                  out_fifo_WREADY,
  output logic                  W_fifo_full,
  output logic                  W_fifo_empty,
  output logic                  W_fifo_almost_full,
  output logic                  W_fifo_almost_empty,
  output logic [CNT_WIDTH-1:0]  W_fifo_count,
  output logic [CNT_WIDTH-1:0]  W_fifo_burst_count
);

  localparam int BEAT_W = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [PTR_W-1:0]     w_ptr;
  logic [PTR_W-1:0]     r_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] burst_count;
  logic                 push;
  logic                 pop;
  logic                 push_last;
  logic                 pop_last;
  logic [BEAT_W-1:0]    wr_beat;
  logic [BEAT_W-1:0]    rd_beat;

  assign W_fifo_full         = (count == CNT_WIDTH'(FIFO_DEPTH));
  assign W_fifo_empty        = (count == '0);
  assign W_fifo_almost_full  = (count >= CNT_WIDTH'(ALMOST_FULL_THRESH));
  assign W_fifo_almost_empty = (count <= CNT_WIDTH'(ALMOST_EMPTY_THRESH));
  assign W_fifo_count        = count;
  assign W_fifo_burst_count  = burst_count;

  // Ready depends only on local state, never on the downstream side, to keep the paths apart.
  assign in_fifo_WREADY = !W_fifo_full && !W_fifo_flush && !W_fifo_rst;
  assign push           = in_fifo_WVALID && in_fifo_WREADY;

  // Store-and-forward holds the head until a whole burst is stored; a full buffer releases
  // anyway so a burst longer than the buffer cannot deadlock.
  assign out_fifo_WVALID = !W_fifo_empty &&
                           ((STORE_FWD == 0) || (burst_count != '0) || W_fifo_full);
  assign pop             = out_fifo_WVALID && out_fifo_WREADY;

  // Storage is unreset; pop gates the head flag so stale contents never reach the counters.
  assign push_last = push && in_fifo_WLAST;
  assign pop_last  = pop && out_fifo_WLAST;

  assign wr_beat = {in_fifo_WLAST, in_fifo_WSTRB, in_fifo_WDATA};
  assign {out_fifo_WLAST, out_fifo_WSTRB, out_fifo_WDATA} = rd_beat;

  w_buf_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (W_fifo_clk),
    .we    (push),
    .waddr (w_ptr),
    .wdata (wr_beat),
    .raddr (r_ptr),
    .rdata (rd_beat)
  );

  always_ff @(posedge W_fifo_clk or posedge W_fifo_rst) begin
    if (W_fifo_rst) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      count       <= '0;
      burst_count <= '0;
    end else if (W_fifo_flush) begin
      // A pop in this cycle still handshakes downstream; its entry is dropped with the rest.
      w_ptr       <= '0;
      r_ptr       <= '0;
      count       <= '0;
      burst_count <= '0;
    end else begin
      if (push) begin
        w_ptr <= PTR_W'(ptr_inc(32'(w_ptr), 32'(FIFO_DEPTH)));
      end
      if (pop) begin
        r_ptr <= PTR_W'(ptr_inc(32'(r_ptr), 32'(FIFO_DEPTH)));
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({push_last, pop_last})
        2'b10:   burst_count <= burst_count + 1'b1;
        2'b01:   burst_count <= burst_count - 1'b1;
        default: burst_count <= burst_count;
      endcase
    end
  end

  always_ff @(posedge W_fifo_clk) begin
    if (!W_fifo_rst && !W_fifo_flush) begin
      assert (!(push && !pop && W_fifo_full))
        else $error("occupancy overflow");
      assert (!(pop && !push && W_fifo_empty))
        else $error("occupancy underflow");
      assert (!(push_last && !pop_last && burst_count == CNT_WIDTH'(FIFO_DEPTH)))
        else $error("burst counter overflow");
      assert (!(pop_last && !push_last && burst_count == '0))
        else $error("burst counter underflow");
      assert (burst_count <= count)
        else $error("more bursts than beats");
    end
  end

endmodule

// File: tb/tb_axi_w_burst_buffer.sv
// tb/tb_axi_w_burst_buffer.sv - self-checking bench for axi_w_burst_buffer against a queue model
module tb_axi_w_burst_buffer;
  import axi_w_buf_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] idata = '0;
  logic [3:0]  istrb = '0;
  logic        ilast = 1'b0;
  logic        ivalid = 1'b0;
  logic        oready = 1'b0;

  logic        wready [2];
  logic [31:0] odata [2];
  logic [3:0]  ostrb [2];
  logic        olast [2];
  logic        ovalid [2];
  logic        full [2];
  logic        empty [2];
  logic        afull [2];
  logic        aempty [2];
  logic [3:0]  cnt [2];
  logic [3:0]  bcnt [2];

  int vectors = 0;
  int miscompares = 0;

  w_beat_t mq0[$];
  w_beat_t mq1[$];

  always #5 clk = ~clk;

  axi_w_burst_buffer #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(32), .STORE_FWD(0)) dut_ct (
    .W_fifo_clk(clk), .W_fifo_rst(rst), .W_fifo_flush(flush),
    .in_fifo_WDATA(idata), .in_fifo_WSTRB(istrb), .in_fifo_WLAST(ilast),
    .in_fifo_WVALID(ivalid), .in_fifo_WREADY(wready[0]),
    .out_fifo_WDATA(odata[0]), .out_fifo_WSTRB(ostrb[0]), .out_fifo_WLAST(olast[0]),
    .out_fifo_WVALID(ovalid[0]), .out_fifo_WREADY(oready),
    .W_fifo_full(full[0]), .W_fifo_empty(empty[0]),
    .W_fifo_almost_full(afull[0]), .W_fifo_almost_empty(aempty[0]),
    .W_fifo_count(cnt[0]), .W_fifo_burst_count(bcnt[0])
  );

  axi_w_burst_buffer #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(32), .STORE_FWD(1)) dut_sf (
    .W_fifo_clk(clk), .W_fifo_rst(rst), .W_fifo_flush(flush),
    .in_fifo_WDATA(idata), .in_fifo_WSTRB(istrb), .in_fifo_WLAST(ilast),
    .in_fifo_WVALID(ivalid), .in_fifo_WREADY(wready[1]),
    .out_fifo_WDATA(odata[1]), .out_fifo_WSTRB(ostrb[1]), .out_fifo_WLAST(olast[1]),
    .out_fifo_WVALID(ovalid[1]), .out_fifo_WREADY(oready),
    .W_fifo_full(full[1]), .W_fifo_empty(empty[1]),
    .W_fifo_almost_full(afull[1]), .W_fifo_almost_empty(aempty[1]),
    .W_fifo_count(cnt[1]), .W_fifo_burst_count(bcnt[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected behaviour from the rules: a beat queue, bursts = beats with WLAST held,
  // store-and-forward presents only with a whole burst held or the buffer full.
  task automatic model_step(input int i, input logic fl, input logic iv, input w_beat_t b,
                            input logic ordy);
    w_beat_t q[$];
    int      bursts;
    int      n;
    logic    ev;
    logic    er;
    string   p;
    if (i == 0) q = mq0; else q = mq1;
    p = (i == 0) ? "ct" : "sf";
    n = q.size();
    bursts = 0;
    foreach (q[k]) if (q[k].wlast) bursts++;
    er = (n < DEPTH) && !fl;
    ev = (n > 0) && ((i == 0) || (bursts > 0) || (n == DEPTH));
    chk({p, ".count"}, 64'(cnt[i]), 64'(n));
    chk({p, ".bursts"}, 64'(bcnt[i]), 64'(bursts));
    chk({p, ".empty"}, 64'(empty[i]), 64'(n == 0));
    chk({p, ".full"}, 64'(full[i]), 64'(n == DEPTH));
    chk({p, ".afull"}, 64'(afull[i]), 64'(n >= DEPTH - 2));
    chk({p, ".aempty"}, 64'(aempty[i]), 64'(n <= 2));
    chk({p, ".wready"}, 64'(wready[i]), 64'(er));
    chk({p, ".wvalid"}, 64'(ovalid[i]), 64'(ev));
    if (ev) begin
      chk({p, ".wdata"}, 64'(odata[i]), 64'(q[0].wdata));
      chk({p, ".wstrb"}, 64'(ostrb[i]), 64'(q[0].wstrb));
      chk({p, ".wlast"}, 64'(olast[i]), 64'(q[0].wlast));
    end
    if (fl) begin
      q.delete();
    end else begin
      if (ev && ordy) void'(q.pop_front());
      if (er && iv) q.push_back(b);
    end
    if (i == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic step(input logic fl, input logic iv, input logic [31:0] d, input logic [3:0] s,
                      input logic l, input logic ordy);
    w_beat_t b;
    b.wdata = d;
    b.wstrb = s;
    b.wlast = l;
    @(negedge clk);
    flush = fl; ivalid = iv; idata = d; istrb = s; ilast = l; oready = ordy;
    #1;
    model_step(0, fl, iv, b, ordy);
    model_step(1, fl, iv, b, ordy);
  endtask

  // Reset lands between edges to exercise its asynchronous effect.
  task automatic do_reset();
    @(negedge clk);
    ivalid = 1'b0; flush = 1'b0; oready = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst.empty", 64'(empty[i]), 64'd1);
      chk("rst.wvalid", 64'(ovalid[i]), 64'd0);
      chk("rst.count", 64'(cnt[i]), 64'd0);
      chk("rst.bursts", 64'(bcnt[i]), 64'd0);
      chk("rst.wready", 64'(wready[i]), 64'd0);
      chk("rst.full", 64'(full[i]), 64'd0);
      chk("rst.aempty", 64'(aempty[i]), 64'd1);
      chk("rst.afull", 64'(afull[i]), 64'd0);
    end
    mq0.delete();
    mq1.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk("rel.wready", 64'(wready[i]), 64'd1);
  endtask

  initial begin
    int bias;

    // T1 reset and idle
    do_reset();
    step(0, 0, 0, 0, 0, 1);

    // T2 fill with downstream stalled, then drain in order
    for (int k = 0; k < 8; k++) step(0, 1, 32'(k), 4'hf, 1'b0, 0);
    step(0, 1, 32'h99, 4'hf, 1'b0, 0);
    for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 0, 1);

    // T3 simultaneous push and pop when full, then at count 3 across the wrap
    for (int k = 0; k < 8; k++) step(0, 1, 32'h100 + 32'(k), 4'h5, 1'(k == 7), 0);
    step(0, 1, 32'h1ff, 4'h3, 1'b0, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) step(0, 1, 32'h200 + 32'(k), 4'(k), 1'(k % 3 == 2), 1);
    do_reset();

    // T4 store-and-forward waits for WLAST
    for (int k = 0; k < 3; k++) step(0, 1, 32'h300 + 32'(k), 4'hf, 1'b0, 1);
    step(0, 1, 32'h303, 4'hf, 1'b1, 1);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0, 1);

    // T5 burst longer than the buffer: full releases the gate
    for (int k = 0; k < 8; k++) step(0, 1, 32'h400 + 32'(k), 4'ha, 1'b0, 0);
    for (int k = 0; k < 12; k++) step(0, 1, 32'h408 + 32'(k), 4'hb, 1'(k == 11), 1);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 1);

    // T6 flush at count 5 with two bursts and a same-cycle push and pop
    for (int k = 0; k < 5; k++) step(0, 1, 32'h500 + 32'(k), 4'hc, 1'(k == 1 || k == 4), 0);
    step(1, 1, 32'hdead, 4'hf, 1'b1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Randomized traffic with shifting downstream pressure, occasional flush and mid-burst reset
    bias = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) bias = $urandom_range(10, 95);
      if (c % 500 == 250) do_reset();
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0), $urandom,
           4'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 99) < bias));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
